tcdm_master_shim: RTL and testbench

Per-initiator adapter between a core/accelerator load-store port (valid/ready request and response streams) and one initiator port of the TCDM interconnect (req/gnt request, fixed-latency `vld`/`rdata` response, no response backpressure). It registers outgoing requests and holds them stable until granted. It buffers responses in a FIFO and uses a credit counter so that no response from the interconnect is ever dropped. One instance sits upstream of each interconnect input `j`.

---
 rtl/tcdm_master_shim.sv | 128 ++++++++++++
 tb/tb_tcdm_master_shim.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_master_shim.sv
// Load-store port to TCDM initiator adapter: registered request with hold-until-grant,
// credit-bounded response FIFO so fixed-latency interconnect responses are never dropped.
module tcdm_master_shim #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned BeWidth        = DataWidth / 8,
    parameter int unsigned RespLat        = 1,
    parameter int unsigned WriteRespOn    = 1,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [AddrWidth-1:0]                req_addr_i,
    input  logic                                req_wen_i,
    input  logic [DataWidth-1:0]                req_wdata_i,
    input  logic [BeWidth-1:0]                  req_be_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [DataWidth-1:0]                rsp_rdata_o,
    output logic                                req_o,
    input  logic                                gnt_i,
    output logic [AddrWidth-1:0]                add_o,
    output logic                                wen_o,
    output logic [DataWidth-1:0]                wdata_o,
    output logic [BeWidth-1:0]                  be_o,
    input  logic                                vld_i,
    input  logic [DataWidth-1:0]                rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                err_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    if (RespLat < 1 || MaxOutstanding < 1) begin : g_bad_param
        $error("tcdm_master_shim: RespLat and MaxOutstanding must be >= 1");
    end

    logic                 hold_vld_q, wen_q;
    logic [AddrWidth-1:0] add_q;
    logic [DataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]   be_q;
    logic [CntW-1:0]      credit_q, credit_d, infl_q, infl_d, count_q, count_d;
    logic [PtrW-1:0]      rptr_q, wptr_q;
    logic [DataWidth-1:0] mem [MaxOutstanding];
    logic                 grant, accept, expect_grant, wr_free, push, pop, err_q;

    assign grant        = hold_vld_q & gnt_i;
    assign req_ready_o  = (!hold_vld_q | gnt_i) & (credit_q < MaxCnt);
    assign accept       = req_valid_i & req_ready_o;
    assign expect_grant = grant & (!wen_q | (WriteRespOn != 0));
    // Writes that never get a response return their credit at grant time.
    assign wr_free      = grant & wen_q & (WriteRespOn == 0);
    assign push         = vld_i & ((infl_q != '0) | expect_grant);
    assign pop          = rsp_valid_o & rsp_ready_i;

    assign req_o         = hold_vld_q;
    assign add_o         = add_q;
    assign wen_o         = wen_q;
    assign wdata_o       = wdata_q;
    assign be_o          = be_q;
    assign rsp_valid_o   = (count_q != '0);
    assign rsp_rdata_o   = rsp_valid_o ? mem[rptr_q] : '0;
    assign outstanding_o = credit_q;
    assign err_o         = err_q;

    always_comb begin
        credit_d = credit_q;
        infl_d   = infl_q;
        count_d  = count_q;
        if (accept)       credit_d = credit_d + CntOne;
        if (pop)          credit_d = credit_d - CntOne;
        if (wr_free)      credit_d = credit_d - CntOne;
        if (expect_grant) infl_d   = infl_d + CntOne;
        if (push)         infl_d   = infl_d - CntOne;
        if (push)         count_d  = count_d + CntOne;
        if (pop)          count_d  = count_d - CntOne;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_vld_q <= 1'b0;
            add_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else if (accept) begin
            hold_vld_q <= 1'b1;
            add_q      <= req_addr_i;
            wen_q      <= req_wen_i;
            wdata_q    <= req_wdata_i;
            be_q       <= req_be_i;
        end else if (grant) begin
            hold_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q <= '0;
            infl_q   <= '0;
            count_q  <= '0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            infl_q   <= infl_d;
            count_q  <= count_d;
            if (push) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrOne;
            if (pop)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrOne;
            if (vld_i && !push) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: the output is gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= rdata_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && count_q == MaxCnt));
endmodule

// File: tb/tb_tcdm_master_shim.sv
// Bench for tcdm_master_shim: a default instance with a scoreboard and a
// MaxOutstanding=2 / WriteRespOn=0 instance driven by hand sequences.
module tb_tcdm_master_shim;
    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 1: defaults (MaxOutstanding=4, WriteRespOn=1)
    logic        req_valid1 = 0, req_wen1 = 0, rsp_ready1 = 1, gnt1 = 1, inj_vld1 = 0;
    logic [31:0] req_addr1 = 0, req_wdata1 = 0;
    logic [3:0]  req_be1 = 0;
    logic        req_ready1, rsp_valid1, ic_req1, ic_wen1, vld1, err1;
    logic [31:0] rsp_rdata1, ic_add1, ic_wdata1, rdata1;
    logic [3:0]  ic_be1;
    logic [2:0]  outst1;
    logic        vld_r1;
    logic [31:0] rd_r1;

    // Instance 2: MaxOutstanding=2, WriteRespOn=0
    logic        req_valid2 = 0, req_wen2 = 0, rsp_ready2 = 1, gnt2 = 1;
    logic [31:0] req_addr2 = 0, req_wdata2 = 0;
    logic [3:0]  req_be2 = 0;
    logic        req_ready2, rsp_valid2, ic_req2, ic_wen2, vld2, err2;
    logic [31:0] rsp_rdata2, ic_add2, ic_wdata2, rdata2;
    logic [3:0]  ic_be2;
    logic [1:0]  outst2;
    logic        vld_r2;
    logic [31:0] rd_r2;

    tcdm_master_shim u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_addr_i(req_addr1),
        .req_wen_i(req_wen1), .req_wdata_i(req_wdata1), .req_be_i(req_be1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_rdata_o(rsp_rdata1),
        .req_o(ic_req1), .gnt_i(gnt1), .add_o(ic_add1), .wen_o(ic_wen1),
        .wdata_o(ic_wdata1), .be_o(ic_be1), .vld_i(vld1), .rdata_i(rdata1),
        .outstanding_o(outst1), .err_o(err1)
    );

    tcdm_master_shim #(.WriteRespOn(0), .MaxOutstanding(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_addr_i(req_addr2),
        .req_wen_i(req_wen2), .req_wdata_i(req_wdata2), .req_be_i(req_be2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
        .req_o(ic_req2), .gnt_i(gnt2), .add_o(ic_add2), .wen_o(ic_wen2),
        .wdata_o(ic_wdata2), .be_o(ic_be2), .vld_i(vld2), .rdata_i(rdata2),
        .outstanding_o(outst2), .err_o(err2)
    );

    // Interconnect model with RespLat=1
    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hCAFE_0000);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            vld_r1 <= 1'b0;
            vld_r2 <= 1'b0;
        end else begin
            vld_r1 <= ic_req1 & gnt1;
            vld_r2 <= ic_req2 & gnt2 & !ic_wen2;
        end
        rd_r1 <= mem_of(ic_add1);
        rd_r2 <= mem_of(ic_add2);
    end
    assign vld1   = vld_r1 | inj_vld1;
    assign rdata1 = rd_r1;
    assign vld2   = vld_r2;
    assign rdata2 = rd_r2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard for instance 1
    logic [31:0] sb[$];
    logic [31:0] exp_cur = 0;
    int pops1 = 0, first_pop = 0, last_pop = 0, grants1 = 0, rsp_seen2 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid1 && req_ready1) sb.push_back(exp_cur);
            if (ic_req1 && gnt1) grants1++;
            if (rsp_valid2) rsp_seen2++;
            if (rsp_valid1 && rsp_ready1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", rsp_rdata1, 32'hXXXXXXXX);
                end else begin
                    chk("sb_rdata", rsp_rdata1, sb.pop_front());
                end
                pops1++;
                if (pops1 == 1) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain1();
        for (int k = 0; k < 60 && (sb.size() != 0 || rsp_valid1); k++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].addr      = 32'h200 + 32'(4 * i);
            tbl[i].wen       = 1'b0;
            tbl[i].wdata     = 32'h0;
            tbl[i].be        = 4'hF;
            tbl[i].exp_rdata = 32'hCAFE_0200 + 32'(4 * i);
        end

        repeat (3) step();
        rst = 1'b0;
        step();
        // Reset state
        chk("rst_req_o", ic_req1, 0);
        chk("rst_req_ready", req_ready1, 1);
        chk("rst_add", ic_add1, 0);
        chk("rst_wdata", ic_wdata1, 0);
        chk("rst_be", ic_be1, 0);
        chk("rst_wen", ic_wen1, 0);
        chk("rst_rsp_valid", rsp_valid1, 0);
        chk("rst_rsp_rdata", rsp_rdata1, 0);
        chk("rst_outstanding", outst1, 0);
        chk("rst_err", err1, 0);
        chk("rst_req_ready2", req_ready2, 1);
        chk("rst_outstanding2", outst2, 0);

        // Single load: accept cycle 0, req_o cycle 1, rsp_valid cycle 3, credit free cycle 4
        req_valid1 = 1; req_addr1 = 32'h40; req_wen1 = 0; req_be1 = 4'hF; exp_cur = 32'hDEADBEEF;
        #1 chk("single_ready", req_ready1, 1);
        step();
        req_valid1 = 0;
        chk("single_req_c1", ic_req1, 1);
        chk("single_add_c1", ic_add1, 32'h40);
        chk("single_out_c1", outst1, 1);
        step();
        chk("single_req_c2", ic_req1, 0);
        chk("single_rspv_c2", rsp_valid1, 0);
        step();
        chk("single_rspv_c3", rsp_valid1, 1);
        chk("single_rdata_c3", rsp_rdata1, 32'hDEADBEEF);
        step();
        chk("single_rspv_c4", rsp_valid1, 0);
        chk("single_out_c4", outst1, 0);
        drain1();

        // Full throughput from the vector table
        pops1 = 0;
        for (int i = 0; i < 16; i++) begin
            req_valid1 = 1; req_addr1 = tbl[i].addr; req_wen1 = tbl[i].wen;
            req_wdata1 = tbl[i].wdata; req_be1 = tbl[i].be; exp_cur = tbl[i].exp_rdata;
            #1 chk("thru_ready", req_ready1, 1);
            step();
        end
        req_valid1 = 0;
        drain1();
        chk("thru_pops", pops1, 16);
        chk("thru_consecutive", last_pop - first_pop, 15);

        // Grant stall on a store
        gnt1 = 0;
        req_valid1 = 1; req_addr1 = 32'h100; req_wen1 = 1; req_wdata1 = 32'h1234; req_be1 = 4'hF;
        exp_cur = 32'hCAFE_0100;
        step();
        req_valid1 = 0; req_addr1 = 32'h999; req_wdata1 = 32'h5555; req_be1 = 4'h1; req_wen1 = 0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_req", ic_req1, 1);
            chk("stall_add", ic_add1, 32'h100);
            chk("stall_wdata", ic_wdata1, 32'h1234);
            chk("stall_be", ic_be1, 4'hF);
            chk("stall_wen", ic_wen1, 1);
            chk("stall_ready", req_ready1, 0);
            step();
        end
        begin
            int g0;
            g0 = grants1;
            gnt1 = 1;
            #1 chk("stall_ready_gnt", req_ready1, 1);
            step();
            chk("stall_req_after", ic_req1, 0);
            chk("stall_one_grant", grants1 - g0, 1);
        end
        drain1();

        // Credit exhaustion on instance 2
        rsp_ready2 = 0;
        req_valid2 = 1; req_addr2 = 32'h300; req_wen2 = 0; req_be2 = 4'hF;
        #1 chk("cred_ready_a", req_ready2, 1);
        step();
        req_addr2 = 32'h304;
        #1 chk("cred_ready_b", req_ready2, 1);
        step();
        req_addr2 = 32'h308;
        #1 chk("cred_ready_c", req_ready2, 0);
        chk("cred_out_full", outst2, 2);
        step();
        step();
        chk("cred_ready_hold", req_ready2, 0);
        chk("cred_head_a", rsp_rdata2, 32'hCAFE_0300);
        rsp_ready2 = 1;
        #1 chk("cred_ready_popcyc", req_ready2, 0);
        step();
        rsp_ready2 = 0;
        #1 chk("cred_ready_after_pop", req_ready2, 1);
        chk("cred_out_after_pop", outst2, 1);
        chk("cred_head_b", rsp_rdata2, 32'hCAFE_0304);
        step();
        req_valid2 = 0;
        chk("cred_out_c", outst2, 2);
        chk("cred_req_c", ic_req2, 1);
        chk("cred_add_c", ic_add2, 32'h308);
        rsp_ready2 = 1;
        step();
        step();
        chk("cred_rspv_c", rsp_valid2, 1);
        chk("cred_head_c", rsp_rdata2, 32'hCAFE_0308);
        step();
        chk("cred_empty", rsp_valid2, 0);
        chk("cred_out_zero", outst2, 0);

        // Stores without write responses on instance 2
        rsp_seen2 = 0;
        for (int k = 0; k < 4; k++) begin
            req_valid2 = 1; req_wen2 = 1; req_addr2 = 32'h400 + 32'(4 * k);
            req_wdata2 = 32'(k + 1); req_be2 = 4'hF;
            #1 chk("wr_ready", req_ready2, 1);
            step();
            req_valid2 = 0;
            chk("wr_req", ic_req2, 1);
            chk("wr_out_accept", outst2, 1);
            step();
            chk("wr_out_granted", outst2, 0);
        end
        repeat (3) step();
        chk("wr_no_rsp", rsp_seen2, 0);
        chk("wr_no_err", err2, 0);

        // Unexpected response while idle
        chk("unexp_err_before", err1, 0);
        inj_vld1 = 1;
        step();
        inj_vld1 = 0;
        chk("unexp_err_set", err1, 1);
        chk("unexp_fifo_empty", rsp_valid1, 0);
        repeat (3) step();
        chk("unexp_err_sticky", err1, 1);
        chk("unexp_fifo_still_empty", rsp_valid1, 0);
        rst = 1;
        step();
        rst = 0;
        chk("unexp_err_cleared", err1, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
